// File: rtl/crc8_arbiter_if.sv
// rtl/crc8_arbiter_if.sv - requester, response and CRC-engine signals of crc8_arbiter
interface crc8_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   rsp_valid_o;
  logic [NUM_REQ-1:0]   rsp_ready_i;
  logic [7:0]           rsp_crc_o;
  logic                 rsp_err_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;
  logic                 crc_clear_o;
  logic                 crc_valid_o;
  logic [7:0]           crc_data_o;
  logic [7:0]           crc_i;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, rsp_ready_i, crc_i,
    output req_ready_o, rsp_valid_o, rsp_crc_o, rsp_err_o, grant_o, busy_o,
           crc_clear_o, crc_valid_o, crc_data_o
  );

  // Producer / engine side
  modport master (
    output req_valid_i, req_data_i, req_last_i, rsp_ready_i, crc_i,
    input  req_ready_o, rsp_valid_o, rsp_crc_o, rsp_err_o, grant_o, busy_o,
           crc_clear_o, crc_valid_o, crc_data_o
  );
endinterface

// File: rtl/crc8_arbiter.sv
// rtl/crc8_arbiter.sv - round-robin sharing of one CRC-8 engine between NUM_REQ frame producers
module crc8_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_LEN = 64
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  crc8_arbiter_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PW-1:0]        gidx_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [7:0]           count_q;
  logic [7:0]           rsp_crc_q;
  logic                 rsp_err_q;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic                 g_valid;
  logic                 g_last;
  logic [7:0]           g_data;
  logic                 hs;
  logic                 len_hit;
  logic                 rsp_take;

  // Granted requester's stream, selected by the registered grant index
  assign g_valid  = bus.req_valid_i[gidx_q];
  assign g_last   = bus.req_last_i[gidx_q];
  assign g_data   = bus.req_data_i[{gidx_q, 3'b000} +: 8];
  assign len_hit  = ({1'b0, count_q} + 9'd1) == 9'(MAX_LEN);
  assign rsp_take = bus.rsp_ready_i[gidx_q];

  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.rsp_crc_o = rsp_crc_q;
  assign bus.rsp_err_o = rsp_err_q;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && bus.req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and combinational engine/handshake outputs
  always_comb begin
    state_d         = state_q;
    hs              = 1'b0;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.crc_clear_o = 1'b0;
    bus.crc_valid_o = 1'b0;
    bus.crc_data_o  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (pick_found) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bus.crc_clear_o = 1'b1;
        state_d         = S_STREAM;
      end
      S_STREAM: begin
        bus.req_ready_o = grant_q;
        bus.crc_valid_o = g_valid;
        bus.crc_data_o  = g_data;
        hs              = g_valid;
        if (g_valid && (g_last || len_hit)) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid_o = grant_q;
        if (rsp_take) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, byte count, response capture and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      count_q   <= 8'h00;
      rsp_crc_q <= 8'h00;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q  <= pick_idx;
          end
        end
        S_CLEAR: begin
          count_q <= 8'h00;
        end
        S_STREAM: begin
          if (hs) begin
            count_q <= count_q + 8'd1;
            // A frame ending without last was cut off at MAX_LEN
            if (g_last || len_hit) rsp_err_q <= ~g_last;
          end
        end
        S_WAIT: begin
          rsp_crc_q <= bus.crc_i;
        end
        S_RESP: begin
          if (rsp_take) begin
            rr_ptr_q <= (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            grant_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_arbiter.sv
// tb/tb_crc8_arbiter.sv - directed self-checking bench for crc8_arbiter
module tb_crc8_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc8_arbiter_if #(.NUM_REQ(4)) bus_a ();
  crc8_arbiter_if #(.NUM_REQ(4)) bus_b ();

  crc8_arbiter #(.NUM_REQ(4), .MAX_LEN(64)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a.slave)
  );

  crc8_arbiter #(.NUM_REQ(4), .MAX_LEN(4)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] msg [0:8];
  logic [7:0] crc_a, crc_b;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // CRC-8 engine models (one per arbiter)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  crc_a <= 8'h00;
    else if (bus_a.crc_clear_o)  crc_a <= 8'h00;
    else if (bus_a.crc_valid_o)  crc_a <= crc8_step(crc_a, bus_a.crc_data_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  crc_b <= 8'h00;
    else if (bus_b.crc_clear_o)  crc_b <= 8'h00;
    else if (bus_b.crc_valid_o)  crc_b <= crc8_step(crc_b, bus_b.crc_data_o);
  end

  assign bus_a.crc_i = crc_a;
  assign bus_b.crc_i = crc_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp_a(input int k, input logic [7:0] ec, input logic ee, input string tag);
    int t;
    t = 0;
    while (bus_a.rsp_valid_o == 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rsp_valid"}, 32'(bus_a.rsp_valid_o), 32'd1 << k);
    chk({tag, "_rsp_crc"},   32'(bus_a.rsp_crc_o),   32'(ec));
    chk({tag, "_rsp_err"},   32'(bus_a.rsp_err_o),   32'(ee));
  endtask

  task automatic send_a(input int k, input int n, input int gap_at, output int lat);
    lat = 0;
    for (int i = 0; i < n; i++) begin
      int t;
      if (i == gap_at) begin
        bus_a.req_valid_i[k] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("gap_crc_valid", 32'(bus_a.crc_valid_o), 32'd0);
        end
      end
      bus_a.req_valid_i[k]        = 1'b1;
      bus_a.req_data_i[8*k +: 8]  = msg[i];
      bus_a.req_last_i[k]         = (i == n - 1);
      t = 0;
      while (!bus_a.req_ready_o[k] && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (i == 0) lat = t;
      #1;
      chk("stream_crc_valid", 32'(bus_a.crc_valid_o), 32'd1);
      chk("stream_crc_data",  32'(bus_a.crc_data_o),  32'(msg[i]));
      @(negedge clk);
    end
    bus_a.req_valid_i[k] = 1'b0;
    bus_a.req_last_i[k]  = 1'b0;
  endtask

  task automatic serve_one(input int j, input logic [7:0] ec, input string tag);
    int t;
    t = 0;
    while (bus_a.grant_o == 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_grant"}, 32'(bus_a.grant_o), 32'd1 << j);
    chk({tag, "_clear"}, 32'(bus_a.crc_clear_o), 32'd1);
    t = 0;
    while (!bus_a.req_ready_o[j] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, 32'(bus_a.req_ready_o), 32'd1 << j);
    @(negedge clk);
    bus_a.req_valid_i[j] = 1'b0;
    bus_a.req_last_i[j]  = 1'b0;
    wait_rsp_a(j, ec, 1'b0, tag);
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(bus_a.rsp_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hs;
    int t;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    bus_a.req_valid_i = '0; bus_a.req_data_i = '0; bus_a.req_last_i = '0; bus_a.rsp_ready_i = '0;
    bus_b.req_valid_i = '0; bus_b.req_data_i = '0; bus_b.req_last_i = '0; bus_b.rsp_ready_i = '0;

    // Reset state
    @(negedge clk);
    chk("rst_grant",     32'(bus_a.grant_o),     32'd0);
    chk("rst_req_ready", 32'(bus_a.req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid_o), 32'd0);
    chk("rst_rsp_crc",   32'(bus_a.rsp_crc_o),   32'd0);
    chk("rst_rsp_err",   32'(bus_a.rsp_err_o),   32'd0);
    chk("rst_busy",      32'(bus_a.busy_o),      32'd0);
    chk("rst_crc_ctl",   32'({bus_a.crc_clear_o, bus_a.crc_valid_o, bus_a.crc_data_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "123456789" from requester 0, response taken immediately
    bus_a.rsp_ready_i = 4'b1111;
    send_a(0, 9, -1, lat);
    chk("t1_first_byte_latency", 32'(lat), 32'd2);
    wait_rsp_a(0, 8'hF4, 1'b0, "t1");
    @(negedge clk);
    chk("t1_rsp_one_cycle", 32'(bus_a.rsp_valid_o), 32'd0);
    chk("t1_crc_held",      32'(bus_a.rsp_crc_o),   32'hF4);
    chk("t1_idle",          32'(bus_a.busy_o),      32'd0);

    // Valid gap mid-frame and response backpressure
    bus_a.rsp_ready_i = 4'b0000;
    send_a(0, 9, 4, lat);
    wait_rsp_a(0, 8'hF4, 1'b0, "bp");
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus_a.rsp_valid_o), 32'd1);
      chk("bp_hold_crc",   32'(bus_a.rsp_crc_o),   32'hF4);
    end
    bus_a.rsp_ready_i = 4'b1111;
    @(negedge clk);
    chk("bp_released", 32'({bus_a.rsp_valid_o, bus_a.busy_o}), 32'd0);

    // Reset in STREAM after two bytes of requester 2
    bus_a.req_valid_i[2] = 1'b1;
    bus_a.req_data_i[23:16] = 8'hAA;
    t = 0;
    while (!bus_a.req_ready_o[2] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("abort_ready", 32'(bus_a.req_ready_o), 32'b0100);
    @(negedge clk);
    bus_a.req_data_i[23:16] = 8'hBB;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_grant",     32'(bus_a.grant_o),     32'd0);
    chk("abort_req_ready", 32'(bus_a.req_ready_o), 32'd0);
    chk("abort_busy",      32'(bus_a.busy_o),      32'd0);
    chk("abort_crc_ctl",   32'({bus_a.crc_clear_o, bus_a.crc_valid_o, bus_a.crc_data_o}), 32'd0);
    bus_a.req_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", 32'({bus_a.rsp_valid_o, bus_a.busy_o}), 32'd0);
    end

    // All four requesters at once, 1-byte frames; rr_ptr restarted at 0
    bus_a.req_data_i  = {8'h04, 8'h03, 8'h02, 8'h01};
    bus_a.req_last_i  = 4'b1111;
    bus_a.req_valid_i = 4'b1111;
    serve_one(0, 8'h07, "rr0");
    serve_one(1, 8'h0E, "rr1");
    serve_one(2, 8'h09, "rr2");
    serve_one(3, 8'h1C, "rr3");

    // Fairness: after 2 is served, 3 goes before 0
    bus_a.req_data_i  = {8'h03, 8'h02, 8'h02, 8'h01};
    bus_a.req_last_i  = 4'b1111;
    bus_a.req_valid_i = 4'b0100;
    @(negedge clk);
    bus_a.req_valid_i = 4'b1101;
    serve_one(2, 8'h0E, "fair2");
    serve_one(3, 8'h09, "fair3");
    serve_one(0, 8'h07, "fair0");

    // MAX_LEN=4 truncation on the second arbiter
    bus_b.rsp_ready_i    = 4'b0000;
    bus_b.req_data_i     = '0;
    bus_b.req_last_i     = '0;
    bus_b.req_valid_i[1] = 1'b1;
    hs = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_b.req_ready_o[1]) hs++;
    end
    chk("trunc_bytes",     32'(hs),                 32'd4);
    chk("trunc_rsp_valid", 32'(bus_b.rsp_valid_o),  32'b0010);
    chk("trunc_rsp_err",   32'(bus_b.rsp_err_o),    32'd1);
    chk("trunc_rsp_crc",   32'(bus_b.rsp_crc_o),    32'h00);
    chk("trunc_no_ready",  32'(bus_b.req_ready_o),  32'd0);
    bus_b.rsp_ready_i = 4'b1111;
    @(negedge clk);
    chk("trunc_idle", 32'({bus_b.grant_o, bus_b.req_ready_o}), 32'd0);
    @(negedge clk);
    chk("trunc_regrant", 32'(bus_b.grant_o), 32'b0010);
    t = 0;
    while (!bus_b.req_ready_o[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("tail_ready5", 32'(bus_b.req_ready_o), 32'b0010);
    @(negedge clk);
    bus_b.req_last_i[1] = 1'b1;
    chk("tail_ready6", 32'(bus_b.req_ready_o), 32'b0010);
    @(negedge clk);
    bus_b.req_valid_i[1] = 1'b0;
    bus_b.req_last_i[1]  = 1'b0;
    t = 0;
    while (bus_b.rsp_valid_o == 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("tail_rsp_valid", 32'(bus_b.rsp_valid_o), 32'b0010);
    chk("tail_rsp_err",   32'(bus_b.rsp_err_o),   32'd0);
    chk("tail_rsp_crc",   32'(bus_b.rsp_crc_o),   32'h00);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
